// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the FFT output serializer.
// The FFT_OUT_DBUF_EN build option is handled in fft_out_serializer.sv.
package fft_pkg;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int dw(input int n);
    return 2 ** n;
  endfunction

  // Bins 0 and N/2 of a real-input FFT carry no imaginary part.
  function automatic logic is_real_bin(input int k);
    return (k == 0) || (k == FRAME_LEN / 2);
  endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Frame-in / sample-out bus of the FFT output serializer.
// master is the serializer side, slave is the stage-3 source plus sample sink.
interface fft_out_serializer_if
  import fft_pkg::*;
#(
  parameter int N = 4
);

  logic                in_valid;
  logic                in_ready;
  logic [dw(N)-1:0]    y0, y4;
  logic [dw(N)-1:0]    yr1, yi1, yr2, yi2, yr3, yi3;
  logic [dw(N)-1:0]    yr5, yi5, yr6, yi6, yr7, yi7;

  logic                out_valid;
  logic                out_ready;
  logic [dw(N)-1:0]    out_re;
  logic [dw(N)-1:0]    out_im;
  logic [IDX_W-1:0]    out_idx;
  logic                out_last;

  modport master (
    input  in_valid, y0, y4, yr1, yi1, yr2, yi2, yr3, yi3,
           yr5, yi5, yr6, yi6, yr7, yi7, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    output in_valid, y0, y4, yr1, yi1, yr2, yi2, yr3, yi3,
           yr5, yi5, yr6, yi6, yr7, yi7, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

endinterface

// File: rtl/fft_frame_buf.sv
// One 8-bin frame register bank (14 live words) with load strobe, async clear
// and a bin-indexed read mux that returns zero imag for the real-only bins.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          load,
  input  logic [FRAME_LEN-1:0][W-1:0]   re_d,
  input  logic [FRAME_LEN-1:0][W-1:0]   im_d,
  input  logic [IDX_W-1:0]              idx,
  output logic [FRAME_LEN-1:0][W-1:0]   re_q,
  output logic [FRAME_LEN-1:0][W-1:0]   im_q,
  output logic [W-1:0]                  re,
  output logic [W-1:0]                  im
);

  // NOTE: this is a small register bank, not a RAM, so it takes the async
  // clear; a reset mid-stream therefore zeroes out_re/out_im immediately.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (load) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        re_q[k] <= re_d[k];
        im_q[k] <= is_real_bin(k) ? '0 : im_d[k];
      end
    end
  end

  assign re = re_q[idx];
  assign im = im_q[idx];

endmodule

// File: rtl/fft_out_serializer.sv
// Serializes one parallel 8-point FFT result frame into 8 complex samples, k=0..7.
// Define FFT_OUT_DBUF_EN to add a shadow frame buffer for back-to-back frames.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int N = 4
) (
  input logic                  clk,
  input logic                  rst,
  fft_out_serializer_if.master bus
);

  localparam int W = dw(N);

  logic [FRAME_LEN-1:0][W-1:0] in_re, in_im;
  logic [FRAME_LEN-1:0][W-1:0] pri_re_d, pri_im_d, pri_re_all, pri_im_all;
  logic [W-1:0]                pri_re, pri_im;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             out_valid_q, out_last_q;
  logic             accept, beat, last_beat, pri_load, next_frame;
  logic             unused_pri;

  assign in_re = {bus.yr7, bus.yr6, bus.yr5, bus.y4, bus.yr3, bus.yr2, bus.yr1, bus.y0};
  assign in_im = {bus.yi7, bus.yi6, bus.yi5, {W{1'b0}}, bus.yi3, bus.yi2, bus.yi1, {W{1'b0}}};

  assign accept    = bus.in_valid && bus.in_ready;
  assign beat      = out_valid_q && bus.out_ready;
  assign last_beat = beat && (idx == IDX_W'(FRAME_LEN - 1));

`ifdef FFT_OUT_DBUF_EN
  logic                        shadow_full, sh_load, swap;
  logic [FRAME_LEN-1:0][W-1:0] sh_re_all, sh_im_all;
  logic [W-1:0]                sh_re_sel, sh_im_sel;
  logic                        unused_sh;

  // A frame arriving mid-stream parks in the shadow bank; one arriving on the
  // final beat can go straight to the primary bank since it frees that edge.
  assign swap       = last_beat && shadow_full;
  assign sh_load    = accept && (state == STREAM) && !last_beat;
  assign pri_load   = (accept && ((state == IDLE) || last_beat)) || swap;
  assign pri_re_d   = swap ? sh_re_all : in_re;
  assign pri_im_d   = swap ? sh_im_all : in_im;
  assign next_frame = swap || accept;
  assign bus.in_ready = rst && !shadow_full;
  assign unused_sh  = ^{sh_re_sel, sh_im_sel};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_full <= 1'b0;
    end else if (sh_load) begin
      shadow_full <= 1'b1;
    end else if (swap) begin
      shadow_full <= 1'b0;
    end
  end

  fft_frame_buf #(.W(W)) u_shadow (
    .clk   (clk),
    .clr_n (rst),
    .load  (sh_load),
    .re_d  (in_re),
    .im_d  (in_im),
    .idx   ('0),
    .re_q  (sh_re_all),
    .im_q  (sh_im_all),
    .re    (sh_re_sel),
    .im    (sh_im_sel)
  );
`else
  assign pri_load   = accept;
  assign pri_re_d   = in_re;
  assign pri_im_d   = in_im;
  assign next_frame = 1'b0;
  assign bus.in_ready = rst && (state == IDLE);
`endif

  fft_frame_buf #(.W(W)) u_primary (
    .clk   (clk),
    .clr_n (rst),
    .load  (pri_load),
    .re_d  (pri_re_d),
    .im_d  (pri_im_d),
    .idx   (idx),
    .re_q  (pri_re_all),
    .im_q  (pri_im_all),
    .re    (pri_re),
    .im    (pri_im)
  );

  assign unused_pri = ^{pri_re_all, pri_im_all};

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= STREAM;
            idx         <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        STREAM: begin
          if (last_beat) begin
            idx        <= '0;
            out_last_q <= 1'b0;
            if (!next_frame) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
            end
          end else if (beat) begin
            idx        <= idx + IDX_W'(1);
            out_last_q <= (idx == IDX_W'(FRAME_LEN - 2));
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_idx   = idx;
  assign bus.out_re    = pri_re;
  assign bus.out_im    = pri_im;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: directed timing checks plus a
// queue-based sample scoreboard fed by randomized frames and backpressure.
module tb_fft_out_serializer;
  import fft_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

`ifdef FFT_OUT_DBUF_EN
  localparam logic RDY_STREAM = 1'b1;
  localparam int   PERIOD     = 8;
  localparam int   T5_ACCEPTS = 2;
`else
  localparam logic RDY_STREAM = 1'b0;
  localparam int   PERIOD     = 9;
  localparam int   T5_ACCEPTS = 1;
`endif

  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t re [FRAME_LEN];
    word_t im [FRAME_LEN];
  } frame_t;
  typedef struct packed {
    word_t      re;
    word_t      im;
    logic [2:0] idx;
    logic       last;
  } samp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_out_serializer_if #(.N(N)) bus ();

  fft_out_serializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: expected sample queue ----------------
  frame_t drv;
  samp_t  exp_q [$];
  int     acc_cyc [$];
  int     n_beats = 0;
  int     cyc = 0;
  samp_t  held;
  logic   stalled = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change 2ns after a rising edge, so at the falling edge they
  // show exactly what the next rising edge will see.
  always @(negedge clk) begin
    samp_t cur, e;
    cur = '{re: bus.out_re, im: bus.out_im, idx: bus.out_idx, last: bus.out_last};
    if (!rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(bus.out_valid), 64'(1));
        check("stall_hold", 64'(cur), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(cur), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_re",   64'(cur.re),   64'(e.re));
          check("beat_im",   64'(cur.im),   64'(e.im));
          check("beat_idx",  64'(cur.idx),  64'(e.idx));
          check("beat_last", 64'(cur.last), 64'(e.last));
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = cur;
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc);
        for (int k = 0; k < FRAME_LEN; k++) begin
          exp_q.push_back('{re:   drv.re[k],
                            im:   ((k == 0) || (k == 4)) ? word_t'(0) : drv.im[k],
                            idx:  3'(k),
                            last: (k == FRAME_LEN - 1)});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < FRAME_LEN; k++) begin
      f.re[k] = W'($urandom);
      f.im[k] = W'($urandom);
    end
    return f;
  endfunction

  task automatic put_frame(input frame_t f);
    drv     = f;
    bus.y0  = f.re[0];
    bus.yr1 = f.re[1]; bus.yi1 = f.im[1];
    bus.yr2 = f.re[2]; bus.yi2 = f.im[2];
    bus.yr3 = f.re[3]; bus.yi3 = f.im[3];
    bus.y4  = f.re[4];
    bus.yr5 = f.re[5]; bus.yi5 = f.im[5];
    bus.yr6 = f.re[6]; bus.yi6 = f.im[6];
    bus.yr7 = f.re[7]; bus.yi7 = f.im[7];
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((bus.out_valid || exp_q.size() != 0) && t < 40) begin
      step();
      t++;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
    check(tag, 64'(bus.out_valid), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    frame_t f;
    int     b0, t, gaps, a0;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    put_frame(rand_frame());

    // Reset values and first cycle after release
    step();
    step();
    check("rst_in_ready",  64'(bus.in_ready),  64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_re",    64'(bus.out_re),    64'(0));
    check("rst_out_im",    64'(bus.out_im),    64'(0));
    check("rst_out_idx",   64'(bus.out_idx),   64'(0));
    check("rst_out_last",  64'(bus.out_last),  64'(0));
    rst = 1'b1;
    #1;
    check("rel_in_ready",  64'(bus.in_ready),  64'(1));
    check("rel_out_valid", 64'(bus.out_valid), 64'(0));

    // Single known frame, sink always ready
    for (int k = 0; k < FRAME_LEN; k++) begin
      f.re[k] = W'(k * 256 + 2);
      f.im[k] = W'(k * 256 + 3);
    end
    f.re[0] = 16'h0001;
    f.re[4] = 16'h0004;
    f.im[0] = 16'hDEAD;
    f.im[4] = 16'hBEEF;
    put_frame(f);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    b0 = n_beats;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      check("t2_valid",    64'(bus.out_valid), 64'(1));
      check("t2_idx",      64'(bus.out_idx),   64'(k));
      check("t2_last",     64'(bus.out_last),  64'(k == FRAME_LEN - 1));
      check("t2_in_ready", 64'(bus.in_ready),  64'(RDY_STREAM));
      if ((k == 0) || (k == 4)) check("t2_im_zero", 64'(bus.out_im), 64'(0));
      step();
    end
    check("t2_done_valid",    64'(bus.out_valid),  64'(0));
    check("t2_done_in_ready", 64'(bus.in_ready),   64'(1));
    check("t2_beats",         64'(n_beats - b0),   64'(8));

    // Backpressure pattern 1,0,0,1 repeating
    put_frame(rand_frame());
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    b0 = n_beats;
    step();
    bus.in_valid = 1'b0;
    t = 0;
    while (bus.out_valid && t < 64) begin
      bus.out_ready = ((t % 4) == 0) || ((t % 4) == 3);
      step();
      t++;
    end
    check("t3_cycles", 64'(t), 64'(16));
    check("t3_beats",  64'(n_beats - b0), 64'(8));
    drain("t3_drain");

    // in_valid held high, sink always ready: frame period
    acc_cyc.delete();
    gaps = 0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      put_frame(rand_frame());
      step();
      if (acc_cyc.size() > 0 && !bus.out_valid) gaps++;
    end
    check("t4_accepts", 64'(acc_cyc.size() >= 4), 64'(1));
    for (int i = 1; i < acc_cyc.size(); i++) begin
`ifdef FFT_OUT_DBUF_EN
      check("t4_period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'((i == 1) ? 1 : PERIOD));
`else
      check("t4_period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(PERIOD));
`endif
    end
`ifdef FFT_OUT_DBUF_EN
    check("t4_gaps", 64'(gaps), 64'(0));
`else
    check("t4_gaps", 64'(gaps), 64'(acc_cyc.size() - 1));
`endif
    drain("t4_drain");

    // Frame offered mid-stream
    acc_cyc.delete();
    put_frame(rand_frame());
    bus.in_valid = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      put_frame(rand_frame());
`ifdef FFT_OUT_DBUF_EN
      check("t5_in_ready", 64'(bus.in_ready), 64'(c == 0));
`else
      check("t5_in_ready", 64'(bus.in_ready), 64'(0));
`endif
      step();
    end
    bus.in_valid = 1'b0;
    drain("t5_drain");
    check("t5_accepts", 64'(acc_cyc.size()), 64'(T5_ACCEPTS));

    // Async reset at idx 4
    put_frame(rand_frame());
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("t6_idx_before", 64'(bus.out_idx), 64'(4));
    #1 rst = 1'b0;
    #1;
    check("t6_out_valid", 64'(bus.out_valid), 64'(0));
    check("t6_out_re",    64'(bus.out_re),    64'(0));
    check("t6_out_im",    64'(bus.out_im),    64'(0));
    check("t6_out_idx",   64'(bus.out_idx),   64'(0));
    check("t6_in_ready",  64'(bus.in_ready),  64'(0));
    step();
    rst = 1'b1;
    #1;
    check("t6_rel_in_ready",  64'(bus.in_ready),  64'(1));
    check("t6_rel_out_valid", 64'(bus.out_valid), 64'(0));
    b0 = n_beats;
    put_frame(rand_frame());
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t6_restart_idx", 64'(bus.out_idx), 64'(0));
    drain("t6_drain");
    check("t6_beats", 64'(n_beats - b0), 64'(8));

`ifdef FFT_OUT_DBUF_EN
    // Second frame into shadow, third held off until the swap
    acc_cyc.delete();
    put_frame(rand_frame());
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    put_frame(rand_frame());
    step();
    put_frame(rand_frame());
    check("t7_full_in_ready", 64'(bus.in_ready), 64'(0));
    t = 0;
    while (acc_cyc.size() < 3 && t < 20) begin
      step();
      t++;
    end
    check("t7_accepts", 64'(acc_cyc.size()), 64'(3));
    a0 = (acc_cyc.size() == 3) ? acc_cyc[2] - acc_cyc[0] : -1;
    check("t7_third_at", 64'(a0), 64'(9));
    drain("t7_drain");
`endif

    // Randomized traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      put_frame(rand_frame());
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain("t8_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
